// File: rtl/arb_pkg.sv
// Shared types and constants for the N-input registered priority / round-robin arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int CNT_W = 8;

endpackage

// File: rtl/prio_enc_n.sv
// Combinational N-input priority encoder; the highest set index wins.
module prio_enc_n #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     in_i,
    output logic [IDX_W-1:0] out_o,
    output logic             valid_o
);

    always_comb begin
        out_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (in_i[i]) begin
                out_o   = IDX_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_arbiter_n.sv
// Registered N-way arbiter: fixed priority or round-robin, grant held until released.
// Optional hold-time limit with forced revoke is built when ARB_TIMEOUT_EN is defined.
module prio_arbiter_n
    import arb_pkg::*;
#(
    parameter int N       = 8,
    parameter int IDX_W   = $clog2(N),
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_i,
    input  logic             mode_i,
    input  logic             release_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o,
    output logic             timeout_o,
    output arb_state_t       state_o
);

    // Handshake: a grant is owned while gnt_valid_o=1; the owner ends it by pulsing
    // release_i for one cycle or by dropping its req bit, and a new owner appears at the next edge.

    arb_state_t       state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             valid_q, valid_d;

    logic [IDX_W-1:0] fix_idx, rr_idx, win_idx;
    logic             fix_valid, rr_valid, win_valid;
    logic [IDX_W-1:0] rr_start, rev_idx, rr_off;
    logic [IDX_W:0]   rr_sum;
    logic [N-1:0]     rot_req, rev_req;
    logic             owner_done, forced, end_grant;
    logic             load, clear;

    prio_enc_n #(.N(N), .IDX_W(IDX_W)) u_fix_enc (
        .in_i    (req_i),
        .out_o   (fix_idx),
        .valid_o (fix_valid)
    );

    // Rotate so (rr_ptr+1) sits at bit 0, then bit-reverse so the first set bit
    // above rr_ptr becomes the highest index seen by the encoder.
    always_comb begin
        rr_start = (rr_ptr_q == IDX_W'(N - 1)) ? '0 : rr_ptr_q + IDX_W'(1);
        rot_req  = N'({req_i, req_i} >> rr_start);
        rev_req  = '0;
        for (int k = 0; k < N; k++) begin
            rev_req[N-1-k] = rot_req[k];
        end
    end

    prio_enc_n #(.N(N), .IDX_W(IDX_W)) u_rr_enc (
        .in_i    (rev_req),
        .out_o   (rev_idx),
        .valid_o (rr_valid)
    );

    always_comb begin
        rr_off = IDX_W'(N - 1) - rev_idx;
        rr_sum = {1'b0, rr_start} + {1'b0, rr_off};
        if (rr_sum >= (IDX_W + 1)'(N)) begin
            rr_sum = rr_sum - (IDX_W + 1)'(N);
        end
        rr_idx = rr_sum[IDX_W-1:0];
    end

    assign win_idx   = (mode_i == MODE_RR) ? rr_idx   : fix_idx;
    assign win_valid = (mode_i == MODE_RR) ? rr_valid : fix_valid;

    assign owner_done = release_i | ~req_i[idx_q];
    assign end_grant  = owner_done | forced;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        rr_ptr_d = rr_ptr_q;
        load     = 1'b0;
        clear    = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    load = 1'b1;
                end
            end
            GRANT: begin
                if (end_grant) begin
                    if (win_valid) begin
                        load = 1'b1;
                    end else begin
                        clear = 1'b1;
                    end
                end
            end
            default: clear = 1'b1;
        endcase

        if (load) begin
            state_d  = GRANT;
            gnt_d    = N'(1) << win_idx;
            idx_d    = win_idx;
            valid_d  = 1'b1;
            rr_ptr_d = win_idx;
        end else if (clear) begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            rr_ptr_q <= IDX_W'(N - 1);
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    assign forced = (state_q == GRANT) && !owner_done &&
                    (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = forced;
        if (load || clear) begin
            cnt_d = '0;
        end else if (state_q == GRANT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    localparam int unused_timeout = TIMEOUT;

    assign forced    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = idx_q;
    assign gnt_valid_o = valid_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_prio_arbiter_n.sv
// Self-checking bench for prio_arbiter_n (N=4, TIMEOUT=4); expected grants are queued per driven cycle.
module tb_prio_arbiter_n;
    import arb_pkg::*;

    localparam int N       = 4;
    localparam int IDX_W   = 2;
    localparam int TIMEOUT = 4;
    localparam int W       = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic             mode;
    logic             rel;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             timeout;
    arb_state_t       st;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    prio_arbiter_n #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .mode_i      (mode),
        .release_i   (rel),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid),
        .timeout_o   (timeout),
        .state_o     (st)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected word layout: {timeout, valid, idx[1:0], gnt[3:0]}.
    function automatic logic [W-1:0] pk(input logic to, input logic v, input logic [1:0] idx);
        logic [3:0] g;
        logic [1:0] i;
        g = v ? (4'b0001 << idx) : 4'b0000;
        i = v ? idx : 2'd0;
        return {to, v, i, g};
    endfunction

    function automatic logic [1:0] hi_bit(input logic [3:0] r);
        logic [1:0] h;
        h = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (r[i]) h = 2'(i);
        end
        return h;
    endfunction

    task automatic compare_out(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_gnt"},     32'(gnt),       32'(e[3:0]));
            check({tag, "_idx"},     32'(gnt_idx),   32'(e[5:4]));
            check({tag, "_valid"},   32'(gnt_valid), 32'(e[6]));
            check({tag, "_timeout"}, 32'(timeout),   32'(e[7]));
            check({tag, "_state"},   32'(st),        e[6] ? 32'(GRANT) : 32'(IDLE));
        end
    endtask

    task automatic step(input string tag, input logic [3:0] r, input logic m, input logic rl,
                        input logic [W-1:0] e);
        req  = r;
        mode = m;
        rel  = rl;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_gnt"},     32'(gnt),       32'd0);
        check({tag, "_idx"},     32'(gnt_idx),   32'd0);
        check({tag, "_valid"},   32'(gnt_valid), 32'd0);
        check({tag, "_timeout"}, 32'(timeout),   32'd0);
        check({tag, "_state"},   32'(st),        32'(IDLE));
    endtask

    logic [3:0] sweep [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hF};

    initial begin
        // Reset held with all requests asserted
        rst_n = 1'b0;
        req   = 4'b1111;
        mode  = MODE_FIXED;
        rel   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step("first_grant", 4'b1111, MODE_FIXED, 1'b0, pk(1'b0, 1'b1, 2'd3));

        // Fixed-priority sweep with release every cycle
        for (int i = 0; i < 10; i++) begin
            step($sformatf("sweep_%0h", sweep[i]), sweep[i], MODE_FIXED, 1'b1,
                 pk(1'b0, sweep[i] != 4'h0, hi_bit(sweep[i])));
        end

        // Round-robin rotation, back-to-back grants
        for (int i = 0; i < 5; i++) begin
            step($sformatf("rr_%0d", i), 4'b1111, MODE_RR, 1'b1, pk(1'b0, 1'b1, 2'(i % 4)));
        end

        // Owner withdraw and drop to idle
        step("own2",      4'b0101, MODE_FIXED, 1'b1, pk(1'b0, 1'b1, 2'd2));
        step("withdraw",  4'b0001, MODE_FIXED, 1'b0, pk(1'b0, 1'b1, 2'd0));
        step("all_drop",  4'b0000, MODE_FIXED, 1'b0, pk(1'b0, 1'b0, 2'd0));

        // Hold against new requests and mode change, then re-grant of the sole requester
        step("hold_load", 4'b0011, MODE_FIXED, 1'b0, pk(1'b0, 1'b1, 2'd1));
        step("hold_req",  4'b1111, MODE_FIXED, 1'b0, pk(1'b0, 1'b1, 2'd1));
        step("hold_mode", 4'b1111, MODE_RR,    1'b0, pk(1'b0, 1'b1, 2'd1));
        step("fix_rewin", 4'b0010, MODE_FIXED, 1'b1, pk(1'b0, 1'b1, 2'd1));
        step("rr_sole",   4'b0010, MODE_RR,    1'b1, pk(1'b0, 1'b1, 2'd1));
        step("to_idle",   4'b0000, MODE_RR,    1'b1, pk(1'b0, 1'b0, 2'd0));

        // Asynchronous reset in the middle of a grant
        step("pre_rst",   4'b1111, MODE_FIXED, 1'b0, pk(1'b0, 1'b1, 2'd3));
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("mid_reset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step("rr_after_rst", 4'b1111, MODE_RR, 1'b0, pk(1'b0, 1'b1, 2'd0));
        step("rr_idle",      4'b0000, MODE_RR, 1'b1, pk(1'b0, 1'b0, 2'd0));

        // Long hold with no release
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            step($sformatf("to_hold_%0d", i), 4'b0011, MODE_RR, 1'b0, pk(1'b0, 1'b1, 2'd1));
        end
        step("to_pulse", 4'b0011, MODE_RR, 1'b0, pk(1'b1, 1'b1, 2'd0));
        for (int i = 0; i < 3; i++) begin
            step($sformatf("to_after_%0d", i), 4'b0011, MODE_RR, 1'b0, pk(1'b0, 1'b1, 2'd0));
        end
        step("to_rel_wins", 4'b0011, MODE_RR, 1'b1, pk(1'b0, 1'b1, 2'd1));
`else
        for (int i = 0; i < 8; i++) begin
            step($sformatf("long_hold_%0d", i), 4'b0011, MODE_RR, 1'b0, pk(1'b0, 1'b1, 2'd1));
        end
        step("long_rel", 4'b0011, MODE_RR, 1'b1, pk(1'b0, 1'b1, 2'd0));
`endif
        step("end_idle", 4'b0000, MODE_RR, 1'b1, pk(1'b0, 1'b0, 2'd0));

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
